// File: rtl/pwm_ramp.sv
// pwm_ramp: soft-start controller for a downstream pwm stage.
//
// A command (target duty select, pwm clock select, step interval) moves
// sel_width one step at a time toward the target, one step every
// cmd_rate+1 clk cycles. On arrival the block sits in HOLD and pulses done
// for one cycle. stop returns the block to OFF, where the pwm stage is held
// in reset (s_rst=1) with sel_width=0.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (see below)
//   cmd_width             target duty select
//   cmd_clk               pwm clock select, used only when starting from OFF
//   cmd_rate              clk cycles between duty steps, minus 1
//   stop                  level-sensitive abort, highest priority
//   sel_width, sel_clk    registered selects to the pwm stage
//   s_rst                 registered synchronous reset to the pwm stage
//   busy                  high while ramping
//   done                  one-cycle pulse when sel_width reaches its target
//   state_dbg             current FSM state (OFF=0, RAMP=1, HOLD=2)
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on registered state and
// stop, never on cmd_valid; the command fields must be stable while
// cmd_valid is high.
module pwm_ramp #(
    parameter int B_WIDTH = 4,
    parameter int B_CLK   = 4,
    parameter int B_RATE  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [B_WIDTH-1:0] cmd_width,
    input  logic [B_CLK-1:0]   cmd_clk,
    input  logic [B_RATE-1:0]  cmd_rate,
    input  logic               stop,
    output logic [B_WIDTH-1:0] sel_width,
    output logic [B_CLK-1:0]   sel_clk,
    output logic               s_rst,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [B_WIDTH-1:0]  width_nxt, width_step;
    logic [B_CLK-1:0]    clk_nxt;
    logic                s_rst_nxt, done_nxt;
    logic [B_RATE-1:0]   timer, timer_nxt;
    logic [B_RATE-1:0]   rate, rate_nxt;
    logic [B_WIDTH-1:0]  target, target_nxt;

    assign cmd_ready = ((state == OFF) || (state == HOLD)) && !stop;
    assign busy      = (state == RAMP);
    assign state_dbg = state;

    always_comb begin
        state_nxt  = state;
        width_nxt  = sel_width;
        clk_nxt    = sel_clk;
        s_rst_nxt  = s_rst;
        timer_nxt  = timer;
        rate_nxt   = rate;
        target_nxt = target;
        done_nxt   = 1'b0;
        // One step toward the target; only used in RAMP, where
        // sel_width != target, so it can never wrap past 0 or all-ones.
        width_step = (sel_width < target) ? sel_width + B_WIDTH'(1)
                                          : sel_width - B_WIDTH'(1);

        if (stop) begin
            state_nxt = OFF;
            width_nxt = '0;
            s_rst_nxt = 1'b1;
            timer_nxt = '0;
        end else begin
            case (state)
                OFF, HOLD: begin
                    if (cmd_valid) begin
                        target_nxt = cmd_width;
                        rate_nxt   = cmd_rate;
                        timer_nxt  = cmd_rate;
                        if (state == OFF) begin
                            // The pwm clock only changes while the pwm
                            // stage is coming out of reset.
                            clk_nxt   = cmd_clk;
                            s_rst_nxt = 1'b0;
                            width_nxt = '0;
                        end
                        if (cmd_width == sel_width) begin
                            state_nxt = HOLD;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (timer != '0) begin
                        timer_nxt = timer - B_RATE'(1);
                    end else begin
                        width_nxt = width_step;
                        timer_nxt = rate;
                        if (width_step == target) begin
                            state_nxt = HOLD;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = OFF;
                    width_nxt = '0;
                    s_rst_nxt = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= OFF;
            sel_width <= '0;
            sel_clk   <= '0;
            s_rst     <= 1'b1;
            done      <= 1'b0;
            timer     <= '0;
            rate      <= '0;
            target    <= '0;
        end else begin
            state     <= state_nxt;
            sel_width <= width_nxt;
            sel_clk   <= clk_nxt;
            s_rst     <= s_rst_nxt;
            done      <= done_nxt;
            timer     <= timer_nxt;
            rate      <= rate_nxt;
            target    <= target_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_ramp.sv
module tb_pwm_ramp;

    localparam int B_WIDTH = 4;
    localparam int B_CLK   = 4;
    localparam int B_RATE  = 16;
    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_RAMP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic               clk;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [B_WIDTH-1:0] cmd_width;
    logic [B_CLK-1:0]   cmd_clk;
    logic [B_RATE-1:0]  cmd_rate;
    logic               stop;
    logic [B_WIDTH-1:0] sel_width;
    logic [B_CLK-1:0]   sel_clk;
    logic               s_rst;
    logic               busy;
    logic               done;
    logic [1:0]         state_dbg;

    int errors = 0;
    int checks = 0;

    pwm_ramp #(.B_WIDTH(B_WIDTH), .B_CLK(B_CLK), .B_RATE(B_RATE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_width (cmd_width),
        .cmd_clk   (cmd_clk),
        .cmd_rate  (cmd_rate),
        .stop      (stop),
        .sel_width (sel_width),
        .sel_clk   (sel_clk),
        .s_rst     (s_rst),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command and returns 1 time unit after the accepting edge.
    task automatic drive_cmd(input logic [B_WIDTH-1:0] w,
                             input logic [B_CLK-1:0] c,
                             input logic [B_RATE-1:0] r);
        cmd_valid = 1'b1;
        cmd_width = w;
        cmd_clk   = c;
        cmd_rate  = r;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Tests
    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; stop = 1'b0;
        cmd_width = '0; cmd_clk = '0; cmd_rate = '0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({state_dbg, sel_width, sel_clk, s_rst, busy, done} !==
            {S_OFF, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: state=%0d width=%0d clk=%0d s_rst=%0b busy=%0b done=%0b, expected 0 0 0 1 0 0",
                     state_dbg, sel_width, sel_clk, s_rst, busy, done);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %0b expected 1", cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Accepted on the first edge after reset release.
    task automatic test_ramp_up();
        int n_done;
        logic [B_WIDTH-1:0] exp_w;
        n_done = 0;
        drive_cmd(4'd5, 4'd3, 16'd2);
        checks++;
        if ({s_rst, sel_clk, sel_width, busy, done} !== {1'b0, 4'd3, 4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL up_accept: s_rst=%0b clk=%0d width=%0d busy=%0b done=%0b, expected 0 3 0 1 0",
                     s_rst, sel_clk, sel_width, busy, done);
        end
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_w = (k >= 15) ? 4'd5 : 4'(k / 3);
            if (done === 1'b1) n_done++;
            checks++;
            if (sel_width !== exp_w) begin
                errors++;
                $display("FAIL up_width@%0d: got %0d expected %0d", k, sel_width, exp_w);
            end
            checks++;
            if (busy !== (k < 15) || done !== (k == 15)) begin
                errors++;
                $display("FAIL up_flags@%0d: busy=%0b done=%0b expected busy=%0b done=%0b",
                         k, busy, done, k < 15, k == 15);
            end
        end
        checks++;
        if (n_done != 1 || state_dbg !== S_HOLD) begin
            errors++;
            $display("FAIL up_end: done_pulses=%0d state=%0d expected 1 and %0d", n_done, state_dbg, S_HOLD);
        end
    endtask

    task automatic test_ramp_down();
        int n_done;
        n_done = 0;
        drive_cmd(4'd2, 4'd7, 16'd0);
        checks++;
        if ({sel_width, busy, sel_clk} !== {4'd5, 1'b1, 4'd3}) begin
            errors++;
            $display("FAIL down_accept: width=%0d busy=%0b clk=%0d expected 5 1 3", sel_width, busy, sel_clk);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (done === 1'b1) n_done++;
            checks++;
            if (sel_width !== 4'((k >= 3) ? 2 : 5 - k) || sel_clk !== 4'd3 || s_rst !== 1'b0) begin
                errors++;
                $display("FAIL down_step@%0d: width=%0d clk=%0d s_rst=%0b expected %0d 3 0",
                         k, sel_width, sel_clk, s_rst, (k >= 3) ? 2 : 5 - k);
            end
        end
        checks++;
        if (n_done != 1 || state_dbg !== S_HOLD) begin
            errors++;
            $display("FAIL down_end: done_pulses=%0d state=%0d expected 1 and %0d", n_done, state_dbg, S_HOLD);
        end
    endtask

    task automatic test_same_target();
        drive_cmd(4'd2, 4'd9, 16'd4);
        checks++;
        if ({sel_width, state_dbg, busy, done} !== {4'd2, S_HOLD, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL same_accept: width=%0d state=%0d busy=%0b done=%0b expected 2 %0d 0 1",
                     sel_width, state_dbg, busy, done, S_HOLD);
        end
        tick();
        checks++;
        if ({sel_width, busy, done, sel_clk} !== {4'd2, 1'b0, 1'b0, 4'd3}) begin
            errors++;
            $display("FAIL same_after: width=%0d busy=%0b done=%0b clk=%0d expected 2 0 0 3",
                     sel_width, busy, done, sel_clk);
        end
    endtask

    task automatic test_stop();
        drive_cmd(4'd9, 4'd6, 16'd1);
        tick();
        tick();
        checks++;
        if (sel_width !== 4'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stop_pre: width=%0d busy=%0b expected 3 1", sel_width, busy);
        end
        stop = 1'b1; cmd_valid = 1'b1; cmd_width = 4'd7; cmd_clk = 4'd5; cmd_rate = 16'd0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL stop_ready: got %0b expected 0", cmd_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if ({state_dbg, sel_width, s_rst, sel_clk, done, busy} !==
                {S_OFF, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stop_off@%0d: state=%0d width=%0d s_rst=%0b clk=%0d done=%0b busy=%0b expected 0 0 1 3 0 0",
                         k, state_dbg, sel_width, s_rst, sel_clk, done, busy);
            end
        end
        stop = 1'b0; cmd_valid = 1'b0;
    endtask

    task automatic test_full_scale();
        int n_done;
        n_done = 0;
        drive_cmd(4'd15, 4'd2, 16'd0);
        checks++;
        if ({sel_clk, s_rst, sel_width} !== {4'd2, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL full_accept: clk=%0d s_rst=%0b width=%0d expected 2 0 0", sel_clk, s_rst, sel_width);
        end
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (done === 1'b1) n_done++;
            checks++;
            if (sel_width !== 4'((k > 15) ? 15 : k)) begin
                errors++;
                $display("FAIL full_width@%0d: got %0d expected %0d", k, sel_width, (k > 15) ? 15 : k);
            end
        end
        checks++;
        if (n_done != 1 || state_dbg !== S_HOLD || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_end: done_pulses=%0d state=%0d busy=%0b expected 1 %0d 0",
                     n_done, state_dbg, busy, S_HOLD);
        end
    endtask

    task automatic test_async_reset();
        drive_cmd(4'd10, 4'd9, 16'd1);
        tick();
        tick();
        checks++;
        if (sel_width !== 4'd14 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: width=%0d busy=%0b expected 14 1", sel_width, busy);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state_dbg, sel_width, sel_clk, s_rst, busy, done, cmd_ready} !==
            {S_OFF, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL arst_immediate: state=%0d width=%0d clk=%0d s_rst=%0b busy=%0b done=%0b ready=%0b expected 0 0 0 1 0 0 1",
                     state_dbg, sel_width, sel_clk, s_rst, busy, done, cmd_ready);
        end
        tick();
        checks++;
        if (done !== 1'b0 || sel_width !== 4'd0) begin
            errors++;
            $display("FAIL arst_hold: done=%0b width=%0d expected 0 0", done, sel_width);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || state_dbg !== S_OFF) begin
            errors++;
            $display("FAIL arst_release: ready=%0b state=%0d expected 1 0", cmd_ready, state_dbg);
        end
    endtask

    // Ramp up from OFF, then a target of 0 from HOLD ramps down with s_rst low.
    task automatic test_ramp_to_zero();
        drive_cmd(4'd2, 4'd1, 16'd0);
        tick();
        tick();
        checks++;
        if ({sel_width, state_dbg, done, sel_clk} !== {4'd2, S_HOLD, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL zero_up: width=%0d state=%0d done=%0b clk=%0d expected 2 %0d 1 1",
                     sel_width, state_dbg, done, sel_clk, S_HOLD);
        end
        drive_cmd(4'd0, 4'd8, 16'd0);
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (sel_width !== 4'(2 - k) || s_rst !== 1'b0) begin
                errors++;
                $display("FAIL zero_down@%0d: width=%0d s_rst=%0b expected %0d 0", k, sel_width, s_rst, 2 - k);
            end
        end
        checks++;
        if ({state_dbg, done, busy, sel_clk} !== {S_HOLD, 1'b1, 1'b0, 4'd1}) begin
            errors++;
            $display("FAIL zero_end: state=%0d done=%0b busy=%0b clk=%0d expected %0d 1 0 1",
                     state_dbg, done, busy, sel_clk, S_HOLD);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_same_target();
        test_stop();
        test_full_scale();
        test_async_reset();
        test_ramp_to_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
